cp_remove: RTL and testbench



---
 rtl/cp_remove.sv | 123 ++++++++++++
 tb/tb_cp_remove.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cp_remove.sv
// Cyclic-prefix removal: drops the guard samples of each OFDM symbol and forwards the NFFT useful samples.
// Latency: 1 cycle. Backpressure: 2-entry output buffer; ack_o drops only while the buffer is full in DATA.
module cp_remove #(
    parameter int NFFT = 256,
    parameter int CW   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dat_in,
    input  logic        cyc_i,
    input  logic        stb_i,
    output logic        ack_o,
    input  logic [1:0]  cp_len,
    output logic [31:0] dat_out,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    input  logic        ack_i,
    output logic        sym_start,
    output logic [7:0]  sym_cnt
);

    typedef enum logic [1:0] {IDLE, CP, DATA} state_t;

    state_t          state, state_nxt;
    logic            cyc_i_pp;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   g_len;
    logic [32:0]     buf_mem [2];
    logic            wr_ptr, rd_ptr;
    logic [1:0]      buf_cnt;
    logic            buf_full, buf_empty;
    logic            frame_rise, up_acc, push, pop;
    logic            cp_last, data_last;

    assign frame_rise = cyc_i & ~cyc_i_pp;
    assign buf_full   = (buf_cnt == 2'd2);
    assign buf_empty  = (buf_cnt == 2'd0);
    assign ack_o      = cyc_i & stb_i & ((state == CP) | ((state == DATA) & ~buf_full));
    assign up_acc     = ack_o;
    assign push       = up_acc & (state == DATA);
    assign pop        = stb_o & ack_i;
    assign cp_last    = (cnt == g_len - CW'(1));
    assign data_last  = (cnt == CW'(NFFT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (frame_rise) state_nxt = CP;
            CP: begin
                if (!cyc_i)                  state_nxt = IDLE;
                else if (up_acc && cp_last)  state_nxt = DATA;
            end
            DATA: begin
                if (!cyc_i)                   state_nxt = IDLE;
                else if (up_acc && data_last) state_nxt = CP;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Guard length is frozen at frame start; later cp_len changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_i_pp <= 1'b0;
            cnt      <= '0;
            g_len    <= '0;
            sym_cnt  <= 8'd0;
        end else begin
            cyc_i_pp <= cyc_i;
            if (state == IDLE && frame_rise) begin
                g_len   <= CW'(NFFT / 4) >> cp_len;
                cnt     <= '0;
                sym_cnt <= 8'd0;
            end else if (up_acc) begin
                if (state == CP) begin
                    cnt <= cp_last ? '0 : cnt + CW'(1);
                end else if (state == DATA) begin
                    cnt <= data_last ? '0 : cnt + CW'(1);
                    if (data_last) sym_cnt <= sym_cnt + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) buf_mem[wr_ptr] <= {(cnt == '0), dat_in};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            buf_cnt <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   buf_cnt <= buf_cnt + 2'd1;
                2'b01:   buf_cnt <= buf_cnt - 2'd1;
                default: buf_cnt <= buf_cnt;
            endcase
        end
    end

    // cyc_o outlives cyc_i until any buffered samples have drained.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     cyc_o <= 1'b0;
        else if (frame_rise)         cyc_o <= 1'b1;
        else if (!cyc_i && buf_empty) cyc_o <= 1'b0;
    end

    assign stb_o     = ~buf_empty;
    assign we_o      = stb_o;
    assign dat_out   = buf_empty ? 32'd0 : buf_mem[rd_ptr][31:0];
    assign sym_start = buf_empty ? 1'b0  : buf_mem[rd_ptr][32];

endmodule

// File: tb/tb_cp_remove.sv
// Bench for cp_remove: directed frames with randomized strobes/backpressure against a symbol-position reference model.
module tb_cp_remove;

    localparam int NFFT = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] dat_in;
    logic        cyc_i, stb_i, ack_o;
    logic [1:0]  cp_len;
    logic [31:0] dat_out;
    logic        cyc_o, stb_o, we_o, ack_i, sym_start;
    logic [7:0]  sym_cnt;

    cp_remove #(.NFFT(NFFT), .CW(8)) dut (
        .clk(clk), .rst(rst), .dat_in(dat_in), .cyc_i(cyc_i), .stb_i(stb_i),
        .ack_o(ack_o), .cp_len(cp_len), .dat_out(dat_out), .cyc_o(cyc_o),
        .stb_o(stb_o), .we_o(we_o), .ack_i(ack_i), .sym_start(sym_start),
        .sym_cnt(sym_cnt)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_fail = 0;

    // Reference model: position of each accepted sample within its frame decides its fate.
    logic [32:0] q[$];
    bit          mdl_active = 1'b0;
    int          mdl_g = 64;
    int          mdl_n = 0;
    int          mdl_sym = 0;
    int          n_out = 0;
    int          n_start = 0;
    int          fbase = 0;
    bit          bp = 1'b0;
    bit          ack_hold = 1'b1;
    int          pos;
    bit          exp_ack;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        assert (got === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        ack_i = bp ? 1'($urandom_range(0, 1)) : ack_hold;
    end

    always @(negedge clk) begin
        if (!rst) begin
            pos = mdl_n % (mdl_g + NFFT);
            exp_ack = mdl_active && cyc_i && stb_i && ((pos < mdl_g) || (q.size() < 2));
            check("ack_o", {63'd0, ack_o}, {63'd0, exp_ack});
            check("stb_o", {63'd0, stb_o}, {63'd0, q.size() != 0});
            check("we_o", {63'd0, we_o}, {63'd0, q.size() != 0});
            if (q.size() == 0) check("empty_out", {31'd0, sym_start, dat_out}, 64'd0);
            if (mdl_active) begin
                check("sym_cnt", {56'd0, sym_cnt}, 64'(mdl_sym));
                check("cyc_o_active", {63'd0, cyc_o}, 64'd1);
            end
            if (stb_o && ack_i && q.size() > 0) begin
                check("head", {31'd0, sym_start, dat_out}, {31'd0, q[0]});
                if (sym_start) n_start++;
                n_out++;
                void'(q.pop_front());
            end
            if (mdl_active && cyc_i && stb_i && ack_o) begin
                if (pos >= mdl_g) q.push_back({pos == mdl_g, dat_in});
                if (pos == mdl_g + NFFT - 1) mdl_sym = (mdl_sym + 1) % 256;
                mdl_n++;
            end
        end
    end

    task automatic start_frame(input int sel);
        cp_len  = 2'(sel);
        mdl_g   = (NFFT / 4) >> sel;
        mdl_n   = 0;
        mdl_sym = 0;
        n_out   = 0;
        n_start = 0;
        fbase   = fbase + 32'h10000;
        cyc_i   = 1'b1;
        stb_i   = 1'b0;
        @(posedge clk); #1;
        mdl_active = 1'b1;
    endtask

    task automatic send(input int start, input int n, input bit rnd);
        int sent = 0;
        int t = 0;
        while (sent < n && t < n * 8 + 100) begin
            stb_i  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            dat_in = 32'(fbase + start + sent);
            @(negedge clk);
            if (cyc_i && stb_i && ack_o) sent++;
            @(posedge clk); #1;
            t++;
        end
        stb_i = 1'b0;
        if (sent < n) check("send_timeout", 64'(sent), 64'(n));
    endtask

    task automatic end_frame();
        int t = 0;
        cyc_i = 1'b0;
        stb_i = 1'b0;
        mdl_active = 1'b0;
        bp = 1'b0;
        ack_hold = 1'b1;
        ack_i = 1'b1;
        while (stb_o && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain", {63'd0, stb_o}, 64'd0);
        check("cyc_o_hold", {63'd0, cyc_o}, 64'd1);
        @(posedge clk); #1;
        check("cyc_o_fall", {63'd0, cyc_o}, 64'd0);
    endtask

    initial begin
        rst = 1'b1; cyc_i = 1'b0; stb_i = 1'b0; dat_in = 32'd0; cp_len = 2'd0; ack_i = 1'b1;
        #3;
        check("rst_ack", {63'd0, ack_o}, 64'd0);
        check("rst_stb", {63'd0, stb_o}, 64'd0);
        check("rst_cyc", {63'd0, cyc_o}, 64'd0);
        check("rst_out", {31'd0, sym_start, dat_out}, 64'd0);
        check("rst_cnt", {56'd0, sym_cnt}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Single symbol, longest guard
        start_frame(0);
        send(0, 320, 1'b0);
        end_frame();
        check("t1_out", 64'(n_out), 64'd256);
        check("t1_start", 64'(n_start), 64'd1);
        check("t1_sym", {56'd0, sym_cnt}, 64'd1);

        // Two symbols, shortest guard
        start_frame(3);
        send(0, 528, 1'b0);
        end_frame();
        check("t2_out", 64'(n_out), 64'd512);
        check("t2_start", 64'(n_start), 64'd2);
        check("t2_sym", {56'd0, sym_cnt}, 64'd2);

        // Random backpressure and strobe gaps, three symbols
        bp = 1'b1;
        start_frame(2);
        send(0, 3 * (16 + NFFT), 1'b1);
        end_frame();
        check("t3_out", 64'(n_out), 64'd768);
        check("t3_start", 64'(n_start), 64'd3);
        check("t3_sym", {56'd0, sym_cnt}, 64'd3);

        // Abort mid-symbol, then a clean frame
        start_frame(0);
        send(0, 100, 1'b0);
        end_frame();
        check("t4_out", 64'(n_out), 64'd36);
        check("t4_sym", {56'd0, sym_cnt}, 64'd0);
        start_frame(0);
        send(0, 320, 1'b0);
        end_frame();
        check("t4b_out", 64'(n_out), 64'd256);
        check("t4b_start", 64'(n_start), 64'd1);

        // Async reset with buffer full in DATA
        ack_hold = 1'b0;
        ack_i = 1'b0;
        start_frame(0);
        send(0, 66, 1'b0);
        check("t5_full", {63'd0, stb_o}, 64'd1);
        #1;
        rst = 1'b1; cyc_i = 1'b0; stb_i = 1'b0;
        mdl_active = 1'b0;
        q.delete();
        #1;
        check("t5_ack", {63'd0, ack_o}, 64'd0);
        check("t5_stb", {63'd0, stb_o}, 64'd0);
        check("t5_we", {63'd0, we_o}, 64'd0);
        check("t5_cyc", {63'd0, cyc_o}, 64'd0);
        check("t5_out", {31'd0, sym_start, dat_out}, 64'd0);
        check("t5_cnt", {56'd0, sym_cnt}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        ack_hold = 1'b1;
        stb_i = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("t5_idle_cyc", {63'd0, cyc_o}, 64'd0);
        check("t5_idle_stb", {63'd0, stb_o}, 64'd0);
        stb_i = 1'b0;

        // cp_len change mid-frame is ignored
        start_frame(1);
        send(0, 100, 1'b0);
        cp_len = 2'd3;
        send(100, 476, 1'b0);
        end_frame();
        check("t6_out", 64'(n_out), 64'd512);
        check("t6_start", 64'(n_start), 64'd2);
        check("t6_sym", {56'd0, sym_cnt}, 64'd2);

        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end

endmodule
